// File: rtl/buzzer_seq_if.sv
// Buzzer sequencer control/status bundle: table load port, playback controls, status and pin.
// Latency: none, wires only.
// Backpressure: none; the application drives table writes and start/stop, and the sequencer reports busy/done.
interface buzzer_seq_if #(
    parameter int AW    = 4,
    parameter int HP_W  = 16,
    parameter int DUR_W = 8
) ();
    // table load port
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [HP_W-1:0]  wr_half;
    logic [DUR_W-1:0] wr_dur;

    // playback control
    logic             start;
    logic             stop;
    logic             loop;

    // status and pin
    logic             busy;
    logic             done;
    logic [AW-1:0]    note_idx;
    logic             buzzer;

    // application side: loads tunes, triggers and observes playback
    modport master (
        output wr_en, wr_addr, wr_half, wr_dur, start, stop, loop,
        input  busy, done, note_idx, buzzer
    );

    // sequencer side
    modport slave (
        input  wr_en, wr_addr, wr_half, wr_dur, start, stop, loop,
        output busy, done, note_idx, buzzer
    );
endinterface

// File: rtl/buzzer_seq.sv
// Melody sequencer: plays a note table (half-period, duration) as a square wave on the buzzer pin.
// Latency: busy rises 1 cycle after start; each note costs 2 silent cycles (fetch, decode) plus dur*TICK_DIV cycles.
// Backpressure: none; start is ignored while busy, stop aborts from any active state on the next cycle.
module buzzer_seq #(
    parameter int TICK_DIV = 10000,
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int HP_W     = 16,
    parameter int DUR_W    = 8
) (
    input  logic         clk,
    input  logic         resetn,
    buzzer_seq_if.slave  bus
);

    // tick counter must hold TICK_DIV-1; keep at least one bit when TICK_DIV is 1
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]    TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
    localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
    localparam logic [HP_W-1:0]  HP_ONE   = HP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_PLAY   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    note_idx_q, note_idx_d;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [HP_W-1:0]  half_cnt_q, half_cnt_d;
    logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
    logic             buzzer_q, buzzer_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // note currently decoded/playing; captured once per fetch so table
    // writes to this entry only show up on its next fetch
    logic [HP_W-1:0]  rd_half_q, rd_half_d;
    logic [DUR_W-1:0] rd_dur_q, rd_dur_d;

    // note table storage (not reset)
    logic [HP_W-1:0]  mem_half_q [DEPTH];
    logic [DUR_W-1:0] mem_dur_q  [DEPTH];

    // decision helpers produced by the next-state logic
    logic             end_song;
    logic             last_cycle;

    // table write port, accepted in every state
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem_half_q[bus.wr_addr] <= bus.wr_half;
            mem_dur_q[bus.wr_addr]  <= bus.wr_dur;
        end
    end

    // state, counters, read register and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            note_idx_q <= '0;
            tick_cnt_q <= '0;
            half_cnt_q <= '0;
            dur_cnt_q  <= '0;
            buzzer_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_half_q  <= '0;
            rd_dur_q   <= '0;
        end else begin
            state_q    <= state_d;
            note_idx_q <= note_idx_d;
            tick_cnt_q <= tick_cnt_d;
            half_cnt_q <= half_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            buzzer_q   <= buzzer_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_half_q  <= rd_half_d;
            rd_dur_q   <= rd_dur_d;
        end
    end

    // next-state, counter and output decode
    always_comb begin
        state_d    = state_q;
        note_idx_d = note_idx_q;
        tick_cnt_d = tick_cnt_q;
        half_cnt_d = half_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        rd_half_d  = rd_half_q;
        rd_dur_d   = rd_dur_q;
        buzzer_d   = 1'b0;   // silent everywhere except PLAY
        done_d     = 1'b0;
        end_song   = 1'b0;
        last_cycle = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    note_idx_d = '0;
                    state_d    = S_FETCH;
                end
            end

            S_FETCH: begin
                rd_half_d = mem_half_q[note_idx_q];
                rd_dur_d  = mem_dur_q[note_idx_q];
                state_d   = S_DECODE;
            end

            S_DECODE: begin
                if (rd_dur_q == '0) begin
                    end_song = 1'b1;
                end else begin
                    dur_cnt_d  = rd_dur_q;
                    tick_cnt_d = '0;
                    half_cnt_d = '0;
                    state_d    = S_PLAY;
                end
            end

            S_PLAY: begin
                buzzer_d = buzzer_q;

                // duration timing: dur ticks of TICK_DIV clocks each
                if (tick_cnt_q == TICK_MAX) begin
                    tick_cnt_d = '0;
                    dur_cnt_d  = dur_cnt_q - DUR_ONE;
                    last_cycle = (dur_cnt_q == DUR_ONE);
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end

                // tone: toggle every half clocks; a zero half-period is a rest
                if (rd_half_q != '0) begin
                    if (half_cnt_q == rd_half_q - HP_ONE) begin
                        buzzer_d   = ~buzzer_q;
                        half_cnt_d = '0;
                    end else begin
                        half_cnt_d = half_cnt_q + 1'b1;
                    end
                end

                if (last_cycle) begin
                    buzzer_d   = 1'b0;
                    half_cnt_d = '0;
                    if (note_idx_q == LAST_IDX) begin
                        // table exhausted without a marker: behave as end-of-song
                        end_song = 1'b1;
                    end else begin
                        note_idx_d = note_idx_q + 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // end-of-song: loop back unless that would replay an empty song from entry 0
        if (end_song) begin
            if (bus.loop && (note_idx_q != '0)) begin
                note_idx_d = '0;
                state_d    = S_FETCH;
            end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end

        // abort overrides everything; note_idx keeps the entry that was active
        if (bus.stop && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            note_idx_d = note_idx_q;
            buzzer_d   = 1'b0;
            done_d     = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.note_idx = note_idx_q;
    assign bus.buzzer   = buzzer_q;

endmodule
